microcode_sequencer: RTL and testbench
======================================

// Module: microcode_sequencer
// PURPOSE
//  Writable ARC control store plus micro-sequencer: CSAR, next-address logic and MIR register in one block.
//  Each enabled clock fetches store[next] into the MIR and drives decoded MIR fields to the datapath.
//  Store is loaded over a write port while halted; readback port for debug. Sits between IR/PSR and datapath.
// PARAMETERS
//  DIR_W    6   register-address field width (A, B, C)
//  ALU_W    4   ALU operation field width
//  COND_W   3   condition field width (must be >=3)
//  JUMP_W   11  jump/CS address width (must be >=11); store depth = 2**JUMP_W
//  MIR_W    3*DIR_W+3+2+ALU_W+COND_W+JUMP_W (41); derived, do not override
// PORTS
//  MICROCODE_STORE_CLOCK_50          in   1       clock, all state on posedge
//  MICROCODE_STORE_ResetInHigh_In    in   1       reset, asynchronous, active-high
//  MICROCODE_STORE_Start_In          in   1       IDLE->RUN request (level, sampled on posedge)
//  MICROCODE_STORE_Halt_In           in   1       RUN->IDLE request; wins over Start
//  MICROCODE_STORE_Enable_In         in   1       step enable in RUN; 0 = stall (hold CSAR, MIR)
//  MICROCODE_STORE_IR_InBus          in   32      instruction register
//  MICROCODE_STORE_Flags_InBus       in   4       PSR {n,z,v,c}
//  MICROCODE_STORE_WrEn_In           in   1       store write strobe
//  MICROCODE_STORE_WrAddr_InBus      in   JUMP_W  store write address
//  MICROCODE_STORE_WrData_InBus      in   MIR_W   store write data
//  MICROCODE_STORE_RdAddr_InBus      in   JUMP_W  readback address
//  MICROCODE_STORE_RdData_OutBus     out  MIR_W   readback data, 1-cycle latency
//  MICROCODE_STORE_Running_Out       out  1       1 in RUN
//  MICROCODE_STORE_ProgErr_Out       out  1       sticky: write attempted while RUN
//  MICROCODE_STORE_CSAddress_OutBus  out  JUMP_W  CSAR (address of instruction in MIR)
//  MICROCODE_STORE_DirA/DirB/DirC_Out     out DIR_W  MIR[MSB..] register fields
//  MICROCODE_STORE_SelectA/B/C_OutBus     out 1      mux selects following each Dir field
//  MICROCODE_STORE_RD_Out / WRMain_Out    out 1      memory read/write
//  MICROCODE_STORE_ALUOperation_OutBus    out ALU_W
//  MICROCODE_STORE_Condition_OutBus       out COND_W
//  MICROCODE_STORE_JumpAddress_OutBus     out JUMP_W
// BEHAVIOUR
//  MIR layout MSB->LSB: DirA,SelA,DirB,SelB,DirC,SelC,RD,WR,ALU,COND,JUMP.
//  Reset: state IDLE, CSAR=0, MIR=0 (all field outputs 0), ProgErr=0, RdData=0. Store NOT reset.
//  States: IDLE, RUN. IDLE&Start&!Halt -> RUN, same edge CSAR<=0, MIR<=store[0] (boot).
//  RUN&Halt -> IDLE, same edge MIR<=0; CSAR holds. RUN&!Halt&Enable: CSAR<=nxt, MIR<=store[nxt].
//  RUN&!Halt&!Enable: CSAR, MIR hold (field outputs stable).
//  nxt from current MIR COND (low 3 bits used; upper bits ignored):
//   0 CSAR+1 | 1 n?JUMP:CSAR+1 | 2 z? | 3 v? | 4 c? | 5 IR[13]? | 6 JUMP | 7 decode.
//  decode address = {1'b1, IR[31:30], IR[24:19], 2'b00}, zero-extended to JUMP_W (ADDCC -> 1600).
//  CSAR+1 wraps modulo 2**JUMP_W (max -> 0).
//  Writes: accepted only in IDLE: store[WrAddr]<=WrData at posedge. WrEn in RUN: ignored, ProgErr<=1 until reset.
//  Write on the Start edge: write completes, boot fetch of address 0 sees OLD data (read-before-write).
//  Readback: RdData<=store[RdAddr] every edge, any state; same-address write shows old data.
//  Reset asserted mid-RUN: immediate return to IDLE, MIR/outputs 0; store contents retained.
//  All field outputs driven directly from MIR flops (registered, no comb paths from inputs).
// TESTING
//  Write store[0]=READ word, store[1]=COND 7; IR=ADDCC (op=10,op3=010000); Start -> CSAR 0,1,1600 on successive edges.
//  MIR COND=5 JUMP=1602 at 1600: IR[13]=1 -> CSAR 1602; IR[13]=0 -> 1601.
//  COND=2 with z=0 -> CSAR+1; z=1 -> JUMP; COND=6 -> JUMP regardless of flags.
//  Enable=0 for 3 cycles mid-RUN -> CSAR/outputs unchanged; Halt -> MIR=0, Running=0.
//  WrEn during RUN -> store unchanged (readback), ProgErr=1; async reset mid-cycle -> outputs 0 before next edge.
//  CSAR=2047 with COND=0 -> next CSAR=0; readback of written word returns data one cycle after RdAddr.

Source files
------------

// File: rtl/microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module : microcode_sequencer
// Writable ARC control store with CSAR, next-address logic and MIR register.
// Rev    : 1.0  initial release
// ============================================================================
module microcode_sequencer #(
  parameter  int DIR_W  = 6,
  parameter  int ALU_W  = 4,
  parameter  int COND_W = 3,
  parameter  int JUMP_W = 11,
  localparam int MIR_W  = 3*DIR_W + 3 + 2 + ALU_W + COND_W + JUMP_W
) (
  input  logic              MICROCODE_STORE_CLOCK_50,
  input  logic              MICROCODE_STORE_ResetInHigh_In,
  input  logic              MICROCODE_STORE_Start_In,
  input  logic              MICROCODE_STORE_Halt_In,
  input  logic              MICROCODE_STORE_Enable_In,
  input  logic [31:0]       MICROCODE_STORE_IR_InBus,
  input  logic [3:0]        MICROCODE_STORE_Flags_InBus,
  input  logic              MICROCODE_STORE_WrEn_In,
  input  logic [JUMP_W-1:0] MICROCODE_STORE_WrAddr_InBus,
  input  logic [MIR_W-1:0]  MICROCODE_STORE_WrData_InBus,
  input  logic [JUMP_W-1:0] MICROCODE_STORE_RdAddr_InBus,
  output logic [MIR_W-1:0]  MICROCODE_STORE_RdData_OutBus,
  output logic              MICROCODE_STORE_Running_Out,
  output logic              MICROCODE_STORE_ProgErr_Out,
  output logic [JUMP_W-1:0] MICROCODE_STORE_CSAddress_OutBus,
  output logic [DIR_W-1:0]  MICROCODE_STORE_DirA_Out,
  output logic [DIR_W-1:0]  MICROCODE_STORE_DirB_Out,
  output logic [DIR_W-1:0]  MICROCODE_STORE_DirC_Out,
  output logic              MICROCODE_STORE_SelectA_OutBus,
  output logic              MICROCODE_STORE_SelectB_OutBus,
  output logic              MICROCODE_STORE_SelectC_OutBus,
  output logic              MICROCODE_STORE_RD_Out,
  output logic              MICROCODE_STORE_WRMain_Out,
  output logic [ALU_W-1:0]  MICROCODE_STORE_ALUOperation_OutBus,
  output logic [COND_W-1:0] MICROCODE_STORE_Condition_OutBus,
  output logic [JUMP_W-1:0] MICROCODE_STORE_JumpAddress_OutBus
);

  localparam int C_COND_LSB = JUMP_W;
  localparam int C_ALU_LSB  = C_COND_LSB + COND_W;
  localparam int C_WR_BIT   = C_ALU_LSB + ALU_W;
  localparam int C_RD_BIT   = C_WR_BIT + 1;
  localparam int C_SELC_BIT = C_RD_BIT + 1;
  localparam int C_DIRC_LSB = C_SELC_BIT + 1;
  localparam int C_SELB_BIT = C_DIRC_LSB + DIR_W;
  localparam int C_DIRB_LSB = C_SELB_BIT + 1;
  localparam int C_SELA_BIT = C_DIRB_LSB + DIR_W;
  localparam int C_DIRA_LSB = C_SELA_BIT + 1;
  localparam int C_DEPTH    = 2**JUMP_W;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [MIR_W-1:0]  r_store [C_DEPTH];
  logic [MIR_W-1:0]  r_mir;
  logic [MIR_W-1:0]  r_rd_data;
  logic [JUMP_W-1:0] r_csar;
  logic              r_prog_err;
  logic [COND_W-1:0] w_cond;
  logic [JUMP_W-1:0] w_jump;
  logic [JUMP_W-1:0] w_csar_inc;
  logic [10:0]       w_decode11;
  logic [JUMP_W-1:0] w_decode;
  logic [JUMP_W-1:0] w_nxt;
  logic [JUMP_W-1:0] w_fetch_addr;
  logic              w_boot;
  logic              w_step;
  logic              w_halt_run;
  logic              w_n, w_z, w_v, w_c;
  logic              w_unused_ir;

  assign w_cond     = r_mir[C_ALU_LSB-1:C_COND_LSB];
  assign w_jump     = r_mir[C_COND_LSB-1:0];
  assign w_csar_inc = r_csar + JUMP_W'(1);
  assign {w_n, w_z, w_v, w_c} = MICROCODE_STORE_Flags_InBus;

  // Opcode dispatch: op and op3 select a 4-word slot in the upper half of the store.
  assign w_decode11 = {1'b1, MICROCODE_STORE_IR_InBus[31:30], MICROCODE_STORE_IR_InBus[24:19], 2'b00};
  assign w_decode   = JUMP_W'(w_decode11);
  assign w_unused_ir = ^{MICROCODE_STORE_IR_InBus[29:25], MICROCODE_STORE_IR_InBus[18:14],
                         MICROCODE_STORE_IR_InBus[12:0]};

  always_comb begin
    w_nxt = w_csar_inc;
    case (w_cond[2:0])
      3'd0:    w_nxt = w_csar_inc;
      3'd1:    w_nxt = w_n ? w_jump : w_csar_inc;
      3'd2:    w_nxt = w_z ? w_jump : w_csar_inc;
      3'd3:    w_nxt = w_v ? w_jump : w_csar_inc;
      3'd4:    w_nxt = w_c ? w_jump : w_csar_inc;
      3'd5:    w_nxt = MICROCODE_STORE_IR_InBus[13] ? w_jump : w_csar_inc;
      3'd6:    w_nxt = w_jump;
      default: w_nxt = w_decode;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_boot      = 1'b0;
    w_step      = 1'b0;
    w_halt_run  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MICROCODE_STORE_Start_In && !MICROCODE_STORE_Halt_In) begin
          w_state_nxt = S_RUN;
          w_boot      = 1'b1;
        end
      end
      S_RUN: begin
        if (MICROCODE_STORE_Halt_In) begin
          w_state_nxt = S_IDLE;
          w_halt_run  = 1'b1;
        end else if (MICROCODE_STORE_Enable_In) begin
          w_step = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_fetch_addr = w_boot ? '0 : w_nxt;

  always_ff @(posedge MICROCODE_STORE_CLOCK_50 or posedge MICROCODE_STORE_ResetInHigh_In) begin
    if (MICROCODE_STORE_ResetInHigh_In) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Halt clears the MIR but keeps CSAR so the stop point stays visible.
  always_ff @(posedge MICROCODE_STORE_CLOCK_50 or posedge MICROCODE_STORE_ResetInHigh_In) begin
    if (MICROCODE_STORE_ResetInHigh_In) begin
      r_csar <= '0;
      r_mir  <= '0;
    end else if (w_halt_run) begin
      r_mir <= '0;
    end else if (w_boot || w_step) begin
      r_csar <= w_fetch_addr;
      r_mir  <= r_store[w_fetch_addr];
    end
  end

  always_ff @(posedge MICROCODE_STORE_CLOCK_50) begin
    if (r_state == S_IDLE && MICROCODE_STORE_WrEn_In) begin
      r_store[MICROCODE_STORE_WrAddr_InBus] <= MICROCODE_STORE_WrData_InBus;
    end
  end

  always_ff @(posedge MICROCODE_STORE_CLOCK_50 or posedge MICROCODE_STORE_ResetInHigh_In) begin
    if (MICROCODE_STORE_ResetInHigh_In) begin
      r_rd_data  <= '0;
      r_prog_err <= 1'b0;
    end else begin
      r_rd_data <= r_store[MICROCODE_STORE_RdAddr_InBus];
      if (r_state == S_RUN && MICROCODE_STORE_WrEn_In) begin
        r_prog_err <= 1'b1;
      end
    end
  end

  assign MICROCODE_STORE_RdData_OutBus       = r_rd_data;
  assign MICROCODE_STORE_Running_Out         = (r_state == S_RUN);
  assign MICROCODE_STORE_ProgErr_Out         = r_prog_err;
  assign MICROCODE_STORE_CSAddress_OutBus    = r_csar;
  assign MICROCODE_STORE_DirA_Out            = r_mir[C_DIRA_LSB +: DIR_W];
  assign MICROCODE_STORE_SelectA_OutBus      = r_mir[C_SELA_BIT];
  assign MICROCODE_STORE_DirB_Out            = r_mir[C_DIRB_LSB +: DIR_W];
  assign MICROCODE_STORE_SelectB_OutBus      = r_mir[C_SELB_BIT];
  assign MICROCODE_STORE_DirC_Out            = r_mir[C_DIRC_LSB +: DIR_W];
  assign MICROCODE_STORE_SelectC_OutBus      = r_mir[C_SELC_BIT];
  assign MICROCODE_STORE_RD_Out              = r_mir[C_RD_BIT];
  assign MICROCODE_STORE_WRMain_Out          = r_mir[C_WR_BIT];
  assign MICROCODE_STORE_ALUOperation_OutBus = r_mir[C_ALU_LSB +: ALU_W];
  assign MICROCODE_STORE_Condition_OutBus    = w_cond;
  assign MICROCODE_STORE_JumpAddress_OutBus  = w_jump;

endmodule
`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_microcode_sequencer
// Directed vector bench for the micro-sequencer and its writable store.
// Rev    : 1.0  initial release
// ============================================================================
module tb_microcode_sequencer;

  localparam logic [31:0] IR13_1 = 32'h8A80_6000;  // ADDCC, IR[13]=1
  localparam logic [31:0] IR13_0 = 32'h8A80_4000;  // ADDCC, IR[13]=0
  localparam int NV = 29;

  logic        clk = 1'b0;
  logic        rst, start, halt, en, wr_en;
  logic [31:0] ir;
  logic [3:0]  flags;
  logic [10:0] wr_addr, rd_addr;
  logic [40:0] wr_data;

  logic [40:0] rd_data;
  logic        running, prog_err;
  logic [10:0] csar, jump;
  logic [5:0]  dira, dirb, dirc;
  logic        sela, selb, selc, rdm, wrm;
  logic [3:0]  alu;
  logic [2:0]  cond;
  logic [40:0] mir_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        start;
    logic        halt;
    logic        en;
    logic [31:0] ir;
    logic [3:0]  flags;
    logic [10:0] csar;
    logic        run;
    logic [40:0] mir;
  } vec_t;

  vec_t tv [NV];

  logic [40:0] w0, w1, w100, w101, w300, w301, w500, w501, w502, w700;
  logic [40:0] w1600, w1601, w1602, w2047, w0alt, wa, wb;

  microcode_sequencer dut (
    .MICROCODE_STORE_CLOCK_50            (clk),
    .MICROCODE_STORE_ResetInHigh_In      (rst),
    .MICROCODE_STORE_Start_In            (start),
    .MICROCODE_STORE_Halt_In             (halt),
    .MICROCODE_STORE_Enable_In           (en),
    .MICROCODE_STORE_IR_InBus            (ir),
    .MICROCODE_STORE_Flags_InBus         (flags),
    .MICROCODE_STORE_WrEn_In             (wr_en),
    .MICROCODE_STORE_WrAddr_InBus        (wr_addr),
    .MICROCODE_STORE_WrData_InBus        (wr_data),
    .MICROCODE_STORE_RdAddr_InBus        (rd_addr),
    .MICROCODE_STORE_RdData_OutBus       (rd_data),
    .MICROCODE_STORE_Running_Out         (running),
    .MICROCODE_STORE_ProgErr_Out         (prog_err),
    .MICROCODE_STORE_CSAddress_OutBus    (csar),
    .MICROCODE_STORE_DirA_Out            (dira),
    .MICROCODE_STORE_DirB_Out            (dirb),
    .MICROCODE_STORE_DirC_Out            (dirc),
    .MICROCODE_STORE_SelectA_OutBus      (sela),
    .MICROCODE_STORE_SelectB_OutBus      (selb),
    .MICROCODE_STORE_SelectC_OutBus      (selc),
    .MICROCODE_STORE_RD_Out              (rdm),
    .MICROCODE_STORE_WRMain_Out          (wrm),
    .MICROCODE_STORE_ALUOperation_OutBus (alu),
    .MICROCODE_STORE_Condition_OutBus    (cond),
    .MICROCODE_STORE_JumpAddress_OutBus  (jump)
  );

  assign mir_out = {dira, sela, dirb, selb, dirc, selc, rdm, wrm, alu, cond, jump};

  always #5 clk = ~clk;

  function automatic logic [40:0] mkw(input logic [5:0] a, input logic [5:0] b,
                                      input logic [5:0] c, input logic [2:0] sel,
                                      input logic rd, input logic wr, input logic [3:0] op,
                                      input logic [2:0] cd, input logic [10:0] jmp);
    return {a, sel[2], b, sel[1], c, sel[0], rd, wr, op, cd, jmp};
  endfunction

  task automatic chk(input string name, input int idx, input logic [40:0] act,
                     input logic [40:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [10:0] a, input logic [40:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic setv(input int i, input logic s, input logic h, input logic e,
                      input logic [31:0] irv, input logic [3:0] f, input logic [10:0] ca,
                      input logic r, input logic [40:0] m);
    tv[i] = '{s, h, e, irv, f, ca, r, m};
  endtask

  initial begin
    w0    = mkw(6'd1,  6'd2,  6'd3,  3'b101, 1'b1, 1'b0, 4'h5, 3'd0, 11'd0);
    w1    = mkw(6'd4,  6'd5,  6'd6,  3'b010, 1'b0, 1'b0, 4'h3, 3'd7, 11'd0);
    w1600 = mkw(6'd7,  6'd8,  6'd9,  3'b111, 1'b0, 1'b1, 4'h1, 3'd5, 11'd1602);
    w1601 = mkw(6'd10, 6'd11, 6'd12, 3'b001, 1'b1, 1'b1, 4'h2, 3'd2, 11'd100);
    w1602 = mkw(6'd13, 6'd14, 6'd15, 3'b100, 1'b0, 1'b0, 4'h4, 3'd6, 11'd2047);
    w2047 = mkw(6'd63, 6'd62, 6'd61, 3'b011, 1'b1, 1'b0, 4'hF, 3'd0, 11'd5);
    w100  = mkw(6'd16, 6'd17, 6'd18, 3'b110, 1'b0, 1'b1, 4'h6, 3'd1, 11'd200);
    w101  = mkw(6'd19, 6'd20, 6'd21, 3'b001, 1'b1, 1'b0, 4'h7, 3'd4, 11'd300);
    w300  = mkw(6'd22, 6'd23, 6'd24, 3'b010, 1'b0, 1'b0, 4'h8, 3'd3, 11'd400);
    w301  = mkw(6'd25, 6'd26, 6'd27, 3'b100, 1'b1, 1'b1, 4'h9, 3'd1, 11'd500);
    w500  = mkw(6'd28, 6'd29, 6'd30, 3'b111, 1'b0, 1'b0, 4'hA, 3'd0, 11'd3);
    w501  = mkw(6'd31, 6'd32, 6'd33, 3'b000, 1'b1, 1'b0, 4'hB, 3'd4, 11'd600);
    w502  = mkw(6'd34, 6'd35, 6'd36, 3'b101, 1'b0, 1'b1, 4'hC, 3'd3, 11'd700);
    w700  = mkw(6'd37, 6'd38, 6'd39, 3'b011, 1'b1, 1'b1, 4'hD, 3'd0, 11'd9);
    w0alt = mkw(6'd40, 6'd41, 6'd42, 3'b110, 1'b0, 1'b1, 4'hE, 3'd6, 11'd1234);
    wa    = 41'h0AB_CDEF_1234;
    wb    = 41'h154_3210_FEDC;

    //      idx start halt en  ir      flags    csar       run   mir
    setv(0,  1'b1, 1'b0, 1'b1, IR13_1, 4'b0000, 11'd0,    1'b1, w0);
    setv(1,  1'b0, 1'b0, 1'b1, IR13_1, 4'b0000, 11'd1,    1'b1, w1);
    setv(2,  1'b0, 1'b0, 1'b1, IR13_1, 4'b0000, 11'd1600, 1'b1, w1600);
    setv(3,  1'b0, 1'b0, 1'b1, IR13_1, 4'b0000, 11'd1602, 1'b1, w1602);
    setv(4,  1'b0, 1'b0, 1'b1, IR13_1, 4'b0000, 11'd2047, 1'b1, w2047);
    setv(5,  1'b0, 1'b0, 1'b1, IR13_1, 4'b0000, 11'd0,    1'b1, w0);
    setv(6,  1'b0, 1'b0, 1'b1, IR13_0, 4'b0000, 11'd1,    1'b1, w1);
    setv(7,  1'b0, 1'b0, 1'b1, IR13_0, 4'b0000, 11'd1600, 1'b1, w1600);
    setv(8,  1'b0, 1'b0, 1'b1, IR13_0, 4'b0000, 11'd1601, 1'b1, w1601);
    setv(9,  1'b0, 1'b0, 1'b1, IR13_0, 4'b1011, 11'd1602, 1'b1, w1602);
    setv(10, 1'b0, 1'b0, 1'b1, IR13_0, 4'b1111, 11'd2047, 1'b1, w2047);
    setv(11, 1'b0, 1'b0, 1'b1, IR13_0, 4'b0000, 11'd0,    1'b1, w0);
    setv(12, 1'b0, 1'b0, 1'b1, IR13_0, 4'b0000, 11'd1,    1'b1, w1);
    setv(13, 1'b0, 1'b0, 1'b1, IR13_0, 4'b0000, 11'd1600, 1'b1, w1600);
    setv(14, 1'b0, 1'b0, 1'b1, IR13_0, 4'b0000, 11'd1601, 1'b1, w1601);
    setv(15, 1'b0, 1'b0, 1'b1, IR13_0, 4'b0100, 11'd100,  1'b1, w100);
    setv(16, 1'b0, 1'b0, 1'b1, IR13_0, 4'b0111, 11'd101,  1'b1, w101);
    setv(17, 1'b0, 1'b0, 1'b1, IR13_0, 4'b0001, 11'd300,  1'b1, w300);
    setv(18, 1'b0, 1'b0, 1'b1, IR13_0, 4'b1101, 11'd301,  1'b1, w301);
    setv(19, 1'b0, 1'b0, 1'b1, IR13_0, 4'b1000, 11'd500,  1'b1, w500);
    setv(20, 1'b0, 1'b0, 1'b0, IR13_0, 4'b1111, 11'd500,  1'b1, w500);
    setv(21, 1'b0, 1'b0, 1'b0, IR13_1, 4'b0000, 11'd500,  1'b1, w500);
    setv(22, 1'b0, 1'b0, 1'b0, IR13_0, 4'b0101, 11'd500,  1'b1, w500);
    setv(23, 1'b0, 1'b0, 1'b1, IR13_0, 4'b0000, 11'd501,  1'b1, w501);
    setv(24, 1'b0, 1'b0, 1'b1, IR13_0, 4'b1110, 11'd502,  1'b1, w502);
    setv(25, 1'b0, 1'b0, 1'b1, IR13_0, 4'b0010, 11'd700,  1'b1, w700);
    setv(26, 1'b1, 1'b1, 1'b1, IR13_0, 4'b0000, 11'd700,  1'b0, 41'd0);
    setv(27, 1'b0, 1'b0, 1'b0, IR13_0, 4'b0000, 11'd700,  1'b0, 41'd0);
    setv(28, 1'b1, 1'b1, 1'b1, IR13_0, 4'b0000, 11'd700,  1'b0, 41'd0);

    rst = 1'b1; start = 1'b0; halt = 1'b0; en = 1'b0; wr_en = 1'b0;
    ir = 32'd0; flags = 4'd0; wr_addr = 11'd0; wr_data = 41'd0; rd_addr = 11'd0;
    tick();
    tick();
    chk("rst_run",  0, 41'(running), 41'd0);
    chk("rst_csar", 0, 41'(csar),    41'd0);
    chk("rst_mir",  0, mir_out,      41'd0);
    chk("rst_perr", 0, 41'(prog_err), 41'd0);
    chk("rst_rdat", 0, rd_data,      41'd0);
    rst = 1'b0;

    wr(11'd0, w0);       wr(11'd1, w1);       wr(11'd1600, w1600);
    wr(11'd1601, w1601); wr(11'd1602, w1602); wr(11'd2047, w2047);
    wr(11'd100, w100);   wr(11'd101, w101);   wr(11'd300, w300);
    wr(11'd301, w301);   wr(11'd500, w500);   wr(11'd501, w501);
    wr(11'd502, w502);   wr(11'd700, w700);
    chk("idle_perr", 0, 41'(prog_err), 41'd0);
    chk("idle_run",  0, 41'(running),  41'd0);

    rd_addr = 11'd1600;
    tick();
    chk("rdback", 1600, rd_data, w1600);

    wr(11'd5, wa);
    rd_addr = 11'd5;
    wr(11'd5, wb);
    chk("rd_old", 5, rd_data, wa);
    tick();
    chk("rd_new", 5, rd_data, wb);

    for (int i = 0; i < NV; i++) begin
      start = tv[i].start; halt = tv[i].halt; en = tv[i].en;
      ir = tv[i].ir; flags = tv[i].flags;
      tick();
      chk("csar", i, 41'(csar),    41'(tv[i].csar));
      chk("run",  i, 41'(running), 41'(tv[i].run));
      chk("mir",  i, mir_out,      tv[i].mir);
    end

    // Write on the boot edge: fetch must see the previous word at address 0.
    halt = 1'b0; start = 1'b1; en = 1'b1; ir = IR13_1; flags = 4'd0;
    wr_en = 1'b1; wr_addr = 11'd0; wr_data = w0alt;
    tick();
    chk("boot_old_mir", 0, mir_out,      w0);
    chk("boot_csar",    0, 41'(csar),    41'd0);
    chk("boot_run",     0, 41'(running), 41'd1);

    start = 1'b0; wr_en = 1'b1; wr_addr = 11'd1; wr_data = 41'h1FF_FFFF_FFFF; rd_addr = 11'd0;
    tick();
    chk("boot_wr_done", 0, rd_data,       w0alt);
    chk("perr_set",     0, 41'(prog_err), 41'd1);
    chk("run_csar",     1, 41'(csar),     41'd1);
    chk("run_mir",      1, mir_out,       w1);

    wr_en = 1'b0; rd_addr = 11'd1;
    tick();
    chk("run_wr_ignored", 1, rd_data,       w1);
    chk("perr_sticky",    0, 41'(prog_err), 41'd1);
    chk("dec_csar",       0, 41'(csar),     41'd1600);

    #3;
    rst = 1'b1;
    #1;
    chk("arst_mir",  0, mir_out,       41'd0);
    chk("arst_csar", 0, 41'(csar),     41'd0);
    chk("arst_run",  0, 41'(running), 41'd0);
    chk("arst_perr", 0, 41'(prog_err), 41'd0);
    chk("arst_rdat", 0, rd_data,       41'd0);
    tick();
    rst = 1'b0; en = 1'b0;
    rd_addr = 11'd0;
    tick();
    chk("retain", 0, rd_data, w0alt);
    rd_addr = 11'd1600;
    tick();
    chk("retain", 1600, rd_data, w1600);
    chk("post_run", 0, 41'(running), 41'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
